analogue_sig_gen_sequencer: RTL and testbench
=============================================

# analogue_sig_gen_sequencer

Run-time controller for the analogue signal generation datapath. Holds the active waveform configuration, accepts new configurations through a valid/ready handshake, divides the system clock down to the sample rate, and steps a DDS phase accumulator. Each sample strobe issues one waveform-table address to the downstream lookup/DAC path. Supports continuous and counted-burst operation, and applies mid-run reconfiguration glitch-free at waveform-cycle boundaries.

## Interface

- PHASE_W, 32, phase accumulator / frequency word width
- ADDR_W, 10, waveform table address width (ADDR_W ≤ PHASE_W)
- DIV_W, 16, sample-rate divider width
- BURST_W, 16, burst cycle count width
- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-high reset
- cfg_valid  in  1  configuration offered
- cfg_ready  out  1  configuration accepted when cfg_valid & cfg_ready at a clk edge
- cfg_freq_word  in  PHASE_W  phase increment per sample
- cfg_phase_offset  in  PHASE_W  accumulator start value
- cfg_div  in  DIV_W  sample period = cfg_div+1 clocks
- cfg_burst_len  in  BURST_W  waveform cycles per burst (0 treated as 1)
- cfg_mode  in  1  0 = continuous, 1 = burst
- start  in  1  level-sampled run request
- stop  in  1  level-sampled abort
- busy  out  1  high in LOAD/RUN/DONE
- sample_stb  out  1  one-clock sample strobe
- sample_addr  out  ADDR_W  table address, valid when sample_stb is high
- cycle_wrap  out  1  pulses with the sample_stb whose increment carries out of the accumulator
- burst_done  out  1  one-clock pulse on burst completion

## Operation

- States: IDLE, LOAD, RUN, DONE. Reset puts the block in IDLE.
- Reset values:
  - All outputs 0; cfg_ready 0 during reset and 1 from the first post-reset cycle.
  - Active config: freq 0, offset 0, div 0, burst_len 1, mode 0. Pending flag clear.
- IDLE:
  - cfg_ready = 1. An accepted config writes the active registers directly.
  - start & !stop → LOAD. stop overrides start.
  - cfg accepted in the same cycle as start: LOAD uses the new config.
- LOAD (1 cycle): phase_acc ← offset, div_cnt ← 0, burst_cnt ← 0. Next state RUN.
- RUN:
  - div_cnt counts 0..div. At div_cnt == div:
    - register sample_stb = 1 and sample_addr = phase_acc[PHASE_W-1 -: ADDR_W], taken before the increment;
    - phase_acc ← phase_acc + freq_word, modulo 2^PHASE_W;
    - div_cnt ← 0.
  - A carry out of that addition asserts cycle_wrap with the same strobe and increments burst_cnt.
  - Burst mode: on the wrap where burst_cnt+1 == max(burst_len,1) → DONE.
  - stop → IDLE at the next edge. No further strobes after the edge where stop is sampled.
- Reconfiguration during RUN:
  - cfg_ready = !pending. An accepted config is stored in shadow registers and sets pending.
  - On the next wrap: shadow → active (freq, div, mode, burst_len), pending clears, burst_cnt ← 0. The phase accumulator is not reloaded; the offset takes effect on the next LOAD.
  - Burst completion on the same wrap takes precedence: → DONE, and pending is applied on entry to IDLE.
  - stop with pending set: pending is applied on entry to IDLE.
- DONE (1 cycle): burst_done = 1 (registered). Next state IDLE.
- freq_word = 0: strobes continue at a constant address and never wrap. In burst mode the run ends only via stop.

## Timing

- start sampled at edge E: LOAD in cycle E+1, RUN from edge E+2. The first sample_stb is high for the cycle after edge E+2+div.
- Strobe spacing is exactly div+1 clocks. div = 0 gives a strobe every clock.
- burst_done rises one cycle after the final wrap strobe. busy falls with burst_done.
- rst mid-run: next edge forces IDLE and clears all outputs, counters and pending. No burst_done is produced.
- All outputs are registered; there is no combinational input-to-output path.

## Structure

- Shared package / defines header (analogue_sig_gen_pkg): state encoding, mode encoding (MODE_CONT, MODE_BURST), default config constants.
- One natural sub-module, sample_rate_divider: div_cnt plus terminal-count tick, with sync clear. All other logic stays in the top FSM.

## Test plan

- Reset, then cfg {freq=2^30, offset=0, div=0, mode=cont}, start → strobes every clock with addr 0,256,512,768,0,…; cycle_wrap on every 4th strobe; busy stays 1.
- div=3, same freq → strobe spacing exactly 4 clocks; first strobe at E+5.
- Burst mode, burst_len=2, freq=2^30 → exactly 8 strobes, then burst_done for 1 clock, then IDLE with busy 0.
- RUN with freq=2^30, offer cfg freq=2^31 mid-cycle → cfg_ready drops; the old increment holds until the wrap; the next addresses step by 512; cfg_ready returns to 1.
- start and stop asserted together in IDLE → stays IDLE, no strobes. stop mid-RUN → no strobe after the edge where stop is sampled. rst mid-burst → all outputs 0 next cycle, no burst_done.
- burst_len=0 in burst mode → behaves as 1: 4 strobes at freq=2^30, then burst_done.

Source files
------------

// File: rtl/analogue_sig_gen_pkg.sv
// Shared encodings and power-on configuration for the analogue signal
// generation sequencer.
package analogue_sig_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic MODE_CONT  = 1'b0;
    localparam logic MODE_BURST = 1'b1;

    // Configuration held in the active registers out of reset
    localparam int   DEF_FREQ_WORD    = 0;
    localparam int   DEF_PHASE_OFFSET = 0;
    localparam int   DEF_DIV          = 0;
    localparam int   DEF_BURST_LEN    = 1;
    localparam logic DEF_MODE         = MODE_CONT;

endpackage

// File: rtl/sample_rate_divider.sv
// Sample-rate divider: counts 0..div while enabled and flags the terminal count.
module sample_rate_divider #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] div_cnt;

    assign tick = en && (div_cnt == div);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            div_cnt <= '0;
        end else if (en) begin
            div_cnt <= tick ? '0 : div_cnt + (DIV_W)'(1);
        end
    end

endmodule

// File: rtl/analogue_sig_gen_sequencer.sv
// Run-time sequencer for the signal generator: config handshake, sample-rate
// division, DDS phase stepping and continuous / counted-burst control.
module analogue_sig_gen_sequencer
    import analogue_sig_gen_pkg::*;
#(
    parameter int PHASE_W = 32,
    parameter int ADDR_W  = 10,
    parameter int DIV_W   = 16,
    parameter int BURST_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [PHASE_W-1:0] cfg_freq_word,
    input  logic [PHASE_W-1:0] cfg_phase_offset,
    input  logic [DIV_W-1:0]   cfg_div,
    input  logic [BURST_W-1:0] cfg_burst_len,
    input  logic               cfg_mode,
    input  logic               start,
    input  logic               stop,
    output logic               busy,
    output logic               sample_stb,
    output logic [ADDR_W-1:0]  sample_addr,
    output logic               cycle_wrap,
    output logic               burst_done
);

    state_t state, state_nxt;

    logic [PHASE_W-1:0] freq_word, phase_offset, phase_acc;
    logic [DIV_W-1:0]   div;
    logic [BURST_W-1:0] burst_len, burst_cnt;
    logic               mode;

    logic [PHASE_W-1:0] sh_freq_word, sh_phase_offset;
    logic [DIV_W-1:0]   sh_div;
    logic [BURST_W-1:0] sh_burst_len;
    logic               sh_mode;
    logic               pending;

    logic               tick, wrap, burst_last;
    logic               accept, direct, apply, pending_nxt;
    logic [PHASE_W:0]   sum;
    logic [BURST_W:0]   burst_target;

    sample_rate_divider #(.DIV_W(DIV_W)) u_divider (
        .clk  (clk),
        .rst  (rst),
        .clr  (state == ST_LOAD),
        .en   (state == ST_RUN),
        .div  (div),
        .tick (tick)
    );

    always_comb begin
        sum          = {1'b0, phase_acc} + {1'b0, freq_word};
        wrap         = tick && sum[PHASE_W];
        burst_target = (burst_len == '0) ? (BURST_W+1)'(1) : {1'b0, burst_len};
        burst_last   = wrap && (mode == MODE_BURST) &&
                       (({1'b0, burst_cnt} + (BURST_W+1)'(1)) == burst_target);

        state_nxt = state;
        case (state)
            ST_IDLE: if (start && !stop) state_nxt = ST_LOAD;
            ST_LOAD: state_nxt = ST_RUN;
            ST_RUN: begin
                if (stop)            state_nxt = ST_IDLE;
                else if (burst_last) state_nxt = ST_DONE;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase

        // Configs land directly in the active set whenever the block is, or is
        // about to be, idle; otherwise they wait in the shadow set for a wrap.
        accept      = cfg_valid && cfg_ready;
        direct      = accept && ((state == ST_IDLE) || (state_nxt == ST_IDLE));
        apply       = pending && ((state_nxt == ST_IDLE) || (wrap && state_nxt == ST_RUN));
        pending_nxt = (pending && !apply) || (accept && !direct);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            freq_word       <= (PHASE_W)'(DEF_FREQ_WORD);
            phase_offset    <= (PHASE_W)'(DEF_PHASE_OFFSET);
            div             <= (DIV_W)'(DEF_DIV);
            burst_len       <= (BURST_W)'(DEF_BURST_LEN);
            mode            <= DEF_MODE;
            sh_freq_word    <= '0;
            sh_phase_offset <= '0;
            sh_div          <= '0;
            sh_burst_len    <= '0;
            sh_mode         <= MODE_CONT;
            pending         <= 1'b0;
            phase_acc       <= '0;
            burst_cnt       <= '0;
            cfg_ready       <= 1'b0;
            busy            <= 1'b0;
            sample_stb      <= 1'b0;
            sample_addr     <= '0;
            cycle_wrap      <= 1'b0;
            burst_done      <= 1'b0;
        end else begin
            sample_stb <= 1'b0;
            cycle_wrap <= 1'b0;
            burst_done <= (state == ST_DONE);
            busy       <= (state_nxt != ST_IDLE);
            pending    <= pending_nxt;
            cfg_ready  <= !pending_nxt;

            if (apply) begin
                freq_word    <= sh_freq_word;
                phase_offset <= sh_phase_offset;
                div          <= sh_div;
                burst_len    <= sh_burst_len;
                mode         <= sh_mode;
            end
            if (direct) begin
                freq_word    <= cfg_freq_word;
                phase_offset <= cfg_phase_offset;
                div          <= cfg_div;
                burst_len    <= cfg_burst_len;
                mode         <= cfg_mode;
            end else if (accept) begin
                sh_freq_word    <= cfg_freq_word;
                sh_phase_offset <= cfg_phase_offset;
                sh_div          <= cfg_div;
                sh_burst_len    <= cfg_burst_len;
                sh_mode         <= cfg_mode;
            end

            if (state == ST_LOAD) begin
                phase_acc <= phase_offset;
                burst_cnt <= '0;
            end else if (state == ST_RUN && tick && !stop) begin
                sample_stb  <= 1'b1;
                sample_addr <= phase_acc[PHASE_W-1 -: ADDR_W];
                phase_acc   <= sum[PHASE_W-1:0];
                if (wrap) begin
                    cycle_wrap <= 1'b1;
                    // A reconfiguration restarts the burst count
                    burst_cnt  <= apply ? '0 : burst_cnt + (BURST_W)'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_analogue_sig_gen_sequencer.sv
// Directed bench for analogue_sig_gen_sequencer: a sample-level model predicts
// every cycle's strobe/addr/wrap/done/busy, plus hand-computed spot checks.
module tb_analogue_sig_gen_sequencer;

    localparam int NC = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid, cfg_ready;
    logic [31:0] cfg_freq_word, cfg_phase_offset;
    logic [15:0] cfg_div, cfg_burst_len;
    logic        cfg_mode, start, stop;
    logic        busy, sample_stb, cycle_wrap, burst_done;
    logic [9:0]  sample_addr;

    analogue_sig_gen_sequencer dut (
        .clk              (clk),
        .rst              (rst),
        .cfg_valid        (cfg_valid),
        .cfg_ready        (cfg_ready),
        .cfg_freq_word    (cfg_freq_word),
        .cfg_phase_offset (cfg_phase_offset),
        .cfg_div          (cfg_div),
        .cfg_burst_len    (cfg_burst_len),
        .cfg_mode         (cfg_mode),
        .start            (start),
        .stop             (stop),
        .busy             (busy),
        .sample_stb       (sample_stb),
        .sample_addr      (sample_addr),
        .cycle_wrap       (cycle_wrap),
        .burst_done       (burst_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    bit         exp_stb [NC];
    bit         exp_wrap[NC];
    bit         exp_done[NC];
    bit         exp_busy[NC];
    logic [9:0] exp_addr[NC];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Walk the run one sample at a time: address is the top bits of the
    // accumulator, a wrap is a carry past 2^32, samples are d+1 clocks apart.
    task automatic plan(input int e, input logic [31:0] f, input logic [31:0] off,
                        input int d, input bit bm, input int bl,
                        input int end_e, input int a_e, input logic [31:0] f2);
        logic [32:0] nxt;
        logic [31:0] acc;
        int t, wraps, last;
        bit pend;
        acc = off; t = e + 2 + d; wraps = 0; last = -1; pend = (a_e > 0);
        while (t < NC - 2) begin
            if (end_e > 0 && t >= end_e) begin last = end_e - 1; break; end
            exp_stb[t]  = 1'b1;
            exp_addr[t] = acc[31:22];
            nxt         = {1'b0, acc} + {1'b0, f};
            exp_wrap[t] = nxt[32];
            acc         = nxt[31:0];
            if (nxt[32]) begin
                wraps++;
                if (bm && wraps >= ((bl == 0) ? 1 : bl)) begin
                    exp_done[t+1] = 1'b1;
                    last = t;
                    break;
                end
                if (pend && t > a_e) begin f = f2; pend = 1'b0; wraps = 0; end
            end
            t += d + 1;
        end
        if (last < 0) last = (end_e > 0) ? end_e - 1 : NC - 1;
        for (int i = e; i <= last; i++) exp_busy[i] = 1'b1;
    endtask

    // Offer a config together with start; end_rel/a_rel are edges after start
    // for the stop (or reset) and for a mid-run frequency change (0 = none).
    task automatic go(input logic [31:0] f, input logic [31:0] off, input int d,
                      input bit bm, input int bl, input int end_rel, input int a_rel,
                      input logic [31:0] f2, output int e);
        e = cyc + 1;
        plan(e, f, off, d, bm, bl, (end_rel > 0) ? e + end_rel : 0,
             (a_rel > 0) ? e + a_rel : 0, f2);
        cfg_valid = 1'b1; cfg_freq_word = f; cfg_phase_offset = off;
        cfg_div = 16'(d); cfg_burst_len = 16'(bl); cfg_mode = bm; start = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0; start = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic stop_at(input int s);
        wait_cyc(s - 1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    always @(negedge clk) begin
        bit ok;
        if (cyc >= 1 && cyc < NC) begin
            ok = (sample_stb == exp_stb[cyc]) && (cycle_wrap == exp_wrap[cyc]) &&
                 (burst_done == exp_done[cyc]) && (busy == exp_busy[cyc]) &&
                 (!exp_stb[cyc] || sample_addr == exp_addr[cyc]);
            n_cmp++;
            if (!ok) begin
                n_bad++;
                if (n_bad <= 20)
                    $display("FAIL model cyc %0d: stb/addr/wrap/done/busy got %0b/%0d/%0b/%0b/%0b expected %0b/%0d/%0b/%0b/%0b",
                             cyc, sample_stb, sample_addr, cycle_wrap, burst_done, busy,
                             exp_stb[cyc], exp_addr[cyc], exp_wrap[cyc], exp_done[cyc], exp_busy[cyc]);
            end
        end
    end

    initial begin
        int e;
        rst = 1'b1; cfg_valid = 1'b0; cfg_freq_word = '0; cfg_phase_offset = '0;
        cfg_div = '0; cfg_burst_len = '0; cfg_mode = 1'b0; start = 1'b0; stop = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cfg_ready", int'(cfg_ready), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_stb", int'(sample_stb), 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_cfg_ready", int'(cfg_ready), 1);
        @(negedge clk);

        // Continuous, div 0, quarter-cycle step
        go(32'h4000_0000, 0, 0, 1'b0, 1, 20, 0, 0, e);
        wait_cyc(e + 2); check("c_addr0", int'(sample_addr), 0);
        check("c_stb0", int'(sample_stb), 1);
        wait_cyc(e + 3); check("c_addr1", int'(sample_addr), 256);
        wait_cyc(e + 4); check("c_addr2", int'(sample_addr), 512);
        wait_cyc(e + 5); check("c_addr3", int'(sample_addr), 768);
        check("c_wrap3", int'(cycle_wrap), 1);
        wait_cyc(e + 6); check("c_addr4", int'(sample_addr), 0);
        stop_at(e + 20);
        repeat (3) @(negedge clk);

        // div 3: first strobe at E+5, spacing 4
        go(32'h4000_0000, 0, 3, 1'b0, 1, 30, 0, 0, e);
        wait_cyc(e + 4); check("d3_nostb_e4", int'(sample_stb), 0);
        wait_cyc(e + 5); check("d3_stb_e5", int'(sample_stb), 1);
        wait_cyc(e + 8); check("d3_nostb_e8", int'(sample_stb), 0);
        wait_cyc(e + 9); check("d3_addr_e9", int'(sample_addr), 256);
        stop_at(e + 30);
        repeat (3) @(negedge clk);

        // Burst of 2 cycles: 8 strobes then burst_done
        go(32'h4000_0000, 0, 0, 1'b1, 2, 0, 0, 0, e);
        wait_cyc(e + 9);  check("b2_last_wrap", int'(cycle_wrap), 1);
        wait_cyc(e + 10); check("b2_done", int'(burst_done), 1);
        check("b2_busy_low", int'(busy), 0);
        wait_cyc(e + 11); check("b2_done_pulse", int'(burst_done), 0);
        repeat (3) @(negedge clk);

        // Mid-run frequency change takes effect after the next wrap
        go(32'h4000_0000, 0, 0, 1'b0, 1, 20, 3, 32'h8000_0000, e);
        wait_cyc(e + 2);
        cfg_valid = 1'b1; cfg_freq_word = 32'h8000_0000;
        @(negedge clk);
        cfg_valid = 1'b0;
        check("rc_ready_low", int'(cfg_ready), 0);
        wait_cyc(e + 4); check("rc_ready_held", int'(cfg_ready), 0);
        wait_cyc(e + 6); check("rc_ready_back", int'(cfg_ready), 1);
        check("rc_addr_e6", int'(sample_addr), 0);
        wait_cyc(e + 7); check("rc_addr_e7", int'(sample_addr), 512);
        check("rc_wrap_e7", int'(cycle_wrap), 1);
        stop_at(e + 20);
        repeat (3) @(negedge clk);

        // start and stop together: nothing happens
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        repeat (3) @(negedge clk);
        check("ss_busy", int'(busy), 0);

        // stop mid-run suppresses the strobe due at the stop edge
        go(32'h4000_0000, 0, 1, 1'b0, 1, 7, 0, 0, e);
        wait_cyc(e + 5); check("sp_addr_e5", int'(sample_addr), 256);
        stop_at(e + 7);
        check("sp_nostb", int'(sample_stb), 0);
        check("sp_busy", int'(busy), 0);
        repeat (3) @(negedge clk);

        // Reset mid-burst: everything clears, no burst_done
        go(32'h4000_0000, 0, 0, 1'b1, 3, 8, 0, 0, e);
        wait_cyc(e + 7);
        rst = 1'b1;
        @(negedge clk);
        check("rr_stb", int'(sample_stb), 0);
        check("rr_busy", int'(busy), 0);
        check("rr_cfg_ready", int'(cfg_ready), 0);
        rst = 1'b0;
        @(negedge clk);
        check("rr_cfg_ready_back", int'(cfg_ready), 1);
        repeat (8) @(negedge clk);

        // burst_len 0 behaves as 1
        go(32'h4000_0000, 0, 0, 1'b1, 0, 0, 0, 0, e);
        wait_cyc(e + 5); check("b0_wrap", int'(cycle_wrap), 1);
        wait_cyc(e + 6); check("b0_done", int'(burst_done), 1);
        repeat (3) @(negedge clk);

        // freq 0 in burst mode: constant address from the offset, only stop ends it
        go(0, 32'h4000_0000, 0, 1'b1, 1, 10, 0, 0, e);
        wait_cyc(e + 2); check("f0_addr_e2", int'(sample_addr), 256);
        wait_cyc(e + 9); check("f0_addr_e9", int'(sample_addr), 256);
        check("f0_stb_e9", int'(sample_stb), 1);
        stop_at(e + 10);
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
